// File: rtl/conv2_layer_ctrl.sv
// Conv2 layer sequencer: walks ch/oy/ox/ky/kx, issues memory addresses, and
// lines up MAC enables behind the memory read latency before each pixel write.
module conv2_layer_ctrl #(
  parameter int IMG_W  = 12,
  parameter int K      = 5,
  parameter int OUT_W  = 8,
  parameter int N_CH   = 3,
  parameter int RD_LAT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [7:0] in_addr,
  output logic [6:0] w_addr,
  output logic       mac_en,
  output logic       mac_first,
  output logic       out_we,
  output logic [5:0] out_addr,
  output logic [1:0] out_ch,
  output logic       busy,
  output logic       done
);

  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int PW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int DW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WRITE, FIN} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     ch_q, ch_d;
  logic [PW-1:0]     oy_q, oy_d, ox_q, ox_d;
  logic [KW-1:0]     ky_q, ky_d, kx_q, kx_d;
  logic [DW-1:0]     drain_q, drain_d;
  logic [RD_LAT-1:0] vld_sr_q, vld_sr_d, first_sr_q, first_sr_d;
  logic [7:0]        in_addr_q, in_addr_d;
  logic [6:0]        w_addr_q, w_addr_d;
  logic [5:0]        out_addr_q, out_addr_d;
  logic [1:0]        out_ch_q, out_ch_d;
  logic              out_we_q, out_we_d, busy_q, busy_d, done_q, done_d;
  logic              last_pixel;

  assign last_pixel = (ch_q == CW'(N_CH - 1)) && (oy_q == PW'(OUT_W - 1)) &&
                      (ox_q == PW'(OUT_W - 1));

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    oy_d    = oy_q;
    ox_d    = ox_q;
    ky_d    = ky_q;
    kx_d    = kx_q;
    drain_d = drain_q;

    case (state_q)
      IDLE: if (start) state_d = ISSUE;
      ISSUE: begin
        if (kx_q == KW'(K - 1)) begin
          kx_d = '0;
          if (ky_q == KW'(K - 1)) begin
            ky_d    = '0;
            state_d = DRAIN;
          end else begin
            ky_d = ky_q + 1'b1;
          end
        end else begin
          kx_d = kx_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == DW'(RD_LAT - 1)) begin
          drain_d = '0;
          state_d = WRITE;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      WRITE: begin
        if (last_pixel) begin
          state_d = FIN;
        end else begin
          state_d = ISSUE;
          if (ox_q == PW'(OUT_W - 1)) begin
            ox_d = '0;
            if (oy_q == PW'(OUT_W - 1)) begin
              oy_d = '0;
              ch_d = ch_q + 1'b1;
            end else begin
              oy_d = oy_q + 1'b1;
            end
          end else begin
            ox_d = ox_q + 1'b1;
          end
        end
      end
      FIN: begin
        ch_d    = '0;
        oy_d    = '0;
        ox_d    = '0;
        ky_d    = '0;
        kx_d    = '0;
        drain_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Each issued tap travels RD_LAT stages so mac_en meets its returning data.
    vld_sr_d[0]   = (state_q == ISSUE);
    first_sr_d[0] = (state_q == ISSUE) && (ky_q == '0) && (kx_q == '0);
    for (int i = 1; i < RD_LAT; i++) begin
      vld_sr_d[i]   = vld_sr_q[i-1];
      first_sr_d[i] = first_sr_q[i-1];
    end

    // Addresses follow the next tap so they hold through DRAIN and WRITE.
    in_addr_d = in_addr_q;
    w_addr_d  = w_addr_q;
    if (state_d == ISSUE) begin
      in_addr_d = 8'((32'(oy_d) + 32'(ky_d)) * 32'(IMG_W) + 32'(ox_d) + 32'(kx_d));
      w_addr_d  = 7'(32'(ch_d) * 32'(K * K) + 32'(ky_d) * 32'(K) + 32'(kx_d));
    end

    out_addr_d = 6'(32'(oy_d) * 32'(OUT_W) + 32'(ox_d));
    out_ch_d   = 2'(ch_d);
    out_we_d   = (state_d == WRITE);
    busy_d     = (state_d == ISSUE) || (state_d == DRAIN) || (state_d == WRITE);
    done_d     = (state_d == FIN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      oy_q       <= '0;
      ox_q       <= '0;
      ky_q       <= '0;
      kx_q       <= '0;
      drain_q    <= '0;
      vld_sr_q   <= '0;
      first_sr_q <= '0;
      in_addr_q  <= '0;
      w_addr_q   <= '0;
      out_addr_q <= '0;
      out_ch_q   <= '0;
      out_we_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      oy_q       <= oy_d;
      ox_q       <= ox_d;
      ky_q       <= ky_d;
      kx_q       <= kx_d;
      drain_q    <= drain_d;
      vld_sr_q   <= vld_sr_d;
      first_sr_q <= first_sr_d;
      in_addr_q  <= in_addr_d;
      w_addr_q   <= w_addr_d;
      out_addr_q <= out_addr_d;
      out_ch_q   <= out_ch_d;
      out_we_q   <= out_we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign in_addr   = in_addr_q;
  assign w_addr    = w_addr_q;
  assign mac_en    = vld_sr_q[RD_LAT-1];
  assign mac_first = first_sr_q[RD_LAT-1];
  assign out_we    = out_we_q;
  assign out_addr  = out_addr_q;
  assign out_ch    = out_ch_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
